cyclic74_serial_dec_ctrl: RTL

//   Bit-serial sequencer for the (7,4) cyclic Hamming decoder, g(x)=x^3+x+1.

---
 rtl/cyclic74_serial_dec_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cyclic74_serial_dec_ctrl.sv
// Bit-serial (7,4) cyclic Hamming decoder, g(x)=x^3+x+1: syndrome division then a
// 7-cycle Meggitt correction pass, with valid/ready on both sides and a saturating error counter.
`timescale 1ns/1ps
module cyclic74_serial_dec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_data,
    output logic             out_err,
    output logic             busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SYND, CORR, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       s_q, s_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       word_q, word_d;
    logic [6:0]       out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic in_xfer, out_xfer, bit_in, fb, corr_e;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign bit_in   = word_q[idx_q];
    assign fb       = s_q[2];
    // x^6 mod g(x) = x^2+1: the syndrome an error in the bit now at the top position leaves
    assign corr_e   = (s_q == 3'b101);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        idx_d       = idx_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d   = SYND;
                    word_d    = in_data;
                    s_d       = '0;
                    idx_d     = 3'd6;
                    out_err_d = 1'b0;
                end
            end
            SYND: begin
                s_d = {s_q[1], s_q[0] ^ fb, bit_in ^ fb};
                if (idx_q == 3'd0) begin
                    state_d = CORR;
                    idx_d   = 3'd6;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            CORR: begin
                out_data_d[idx_q] = bit_in ^ corr_e;
                out_err_d         = out_err_q | corr_e;
                s_d = corr_e ? 3'b000 : {s_q[1], s_q[0] ^ s_q[2], s_q[2]};
                if (idx_q == 3'd0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            DONE: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    if (in_xfer) begin
                        state_d   = SYND;
                        word_d    = in_data;
                        s_d       = '0;
                        idx_d     = 3'd6;
                        out_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            err_cnt_d = '0;
        end else if (out_xfer && out_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != IDLE);
    assign err_cnt   = err_cnt_q;

endmodule
